scandoubler: RTL and testbench



---
 rtl/scandoubler_pkg.sv | 23 ++
 rtl/scandoubler_linebuf.sv | 28 ++
 rtl/scandoubler.sv | 201 ++++++++++++++++++++
 tb/tb_scandoubler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared pixel format and sync polarity for the scandoubler.
package scandoubler_pkg;

    localparam int   CH_W     = 5;
    localparam int   PIX_W    = 3 * CH_W;
    localparam logic SYNC_ACT = 1'b0;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // Half intensity on every channel, used for the scanline effect.
    function automatic rgb_t dim_pix(input rgb_t p);
        rgb_t q;
        q.r = p.r >> 1;
        q.g = p.g >> 1;
        q.b = p.b >> 1;
        return q;
    endfunction

endpackage

// File: rtl/scandoubler_linebuf.sv
// Two-bank line store: one write port, one registered read port.
module scandoubler_linebuf
    import scandoubler_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_idx,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [0:2*DEPTH-1];

    // Plain RAM write plus registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_idx}];
    end

endmodule

// File: rtl/scandoubler.sv
// 15 kHz -> 31 kHz line doubler: capture a line, replay it twice at double rate.
module scandoubler
    import scandoubler_pkg::*;
#(
    parameter int HCNT_W    = 11,
    parameter int BUF_DEPTH = 1024
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       ce_in,
    input  logic [4:0] r_in,
    input  logic [4:0] g_in,
    input  logic [4:0] b_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       scanlines,
    output logic [4:0] r_out,
    output logic [4:0] g_out,
    output logic [4:0] b_out,
    output logic       hs_out,
    output logic       vs_out
);

    localparam int                AW       = $clog2(BUF_DEPTH);
    localparam logic [HCNT_W-1:0] HCNT_MAX = {HCNT_W{1'b1}};
    localparam logic [AW-1:0]     X_LAST   = AW'(BUF_DEPTH - 1);

    logic              hs_d;
    logic              line_start;
    logic              hs_rise;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] line_len;
    logic [HCNT_W-1:0] half;
    logic [HCNT_W-1:0] hs_cnt;
    logic [HCNT_W-1:0] hs_w;
    logic [HCNT_W-1:0] out_cnt;
    logic [AW-1:0]     in_x;
    logic              wr_full;
    logic              wr_bank;
    logic              rd_bank;
    logic              rep;
    logic              e_seen;
    logic              valid;
    logic              we;
    logic [PIX_W-1:0]  rd_data;
    rgb_t              rd_pix;
    rgb_t              out_pix;
    logic              hs_int;
    logic              hs_s1;
    logic              vs_s1;
    logic              rep_s1;
    logic              valid_s1;

    assign line_start = (hs_d != SYNC_ACT) && (hs_in == SYNC_ACT);
    assign hs_rise    = (hs_d == SYNC_ACT) && (hs_in != SYNC_ACT);
    assign half       = line_len >> 1;
    assign we         = ce_in && !wr_full;
    assign hs_int     = (out_cnt < (hs_w >> 1)) ? SYNC_ACT : ~SYNC_ACT;
    assign rd_pix     = rgb_t'(rd_data);

    // Sync edge detect, line-length and sync-width measurement.
    // line_len counts the E cycle itself, so it equals the input line period.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_d     <= 1'b0;
            hcnt     <= '0;
            line_len <= '0;
            hs_cnt   <= '0;
            hs_w     <= '0;
        end else begin
            hs_d <= hs_in;
            if (line_start) begin
                line_len <= (hcnt == HCNT_MAX) ? HCNT_MAX : hcnt + 1'b1;
                hcnt     <= '0;
            end else if (hcnt != HCNT_MAX) begin
                hcnt <= hcnt + 1'b1;
            end
            if (hs_rise) begin
                hs_w   <= hs_cnt;
                hs_cnt <= '0;
            end else if (hs_in == SYNC_ACT && hs_cnt != HCNT_MAX) begin
                hs_cnt <= hs_cnt + 1'b1;
            end
        end
    end

    // Write side: fill the current bank, keep the first pixel landing at the last slot.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            in_x    <= '0;
            wr_full <= 1'b0;
            wr_bank <= 1'b0;
        end else if (line_start) begin
            in_x    <= '0;
            wr_full <= 1'b0;
            wr_bank <= ~wr_bank;
        end else if (we) begin
            if (in_x == X_LAST) begin
                wr_full <= 1'b1;
            end else begin
                in_x <= in_x + 1'b1;
            end
        end
    end

    // Read side: two passes of half a line each, then park until the next line start.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            rd_bank <= 1'b0;
            out_cnt <= '0;
            rep     <= 1'b0;
        end else if (line_start) begin
            rd_bank <= wr_bank;
            out_cnt <= '0;
            rep     <= 1'b0;
        end else if (out_cnt == half - 1'b1) begin
            if (!rep) begin
                out_cnt <= '0;
                rep     <= 1'b1;
            end
        end else begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

    // Output is trusted only once a full line has been captured (second line start).
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            e_seen <= 1'b0;
            valid  <= 1'b0;
        end else if (line_start) begin
            e_seen <= 1'b1;
            if (e_seen) begin
                valid <= 1'b1;
            end
        end
    end

    // First pipeline stage, aligned with the registered RAM read.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_s1    <= ~SYNC_ACT;
            vs_s1    <= ~SYNC_ACT;
            rep_s1   <= 1'b0;
            valid_s1 <= 1'b0;
        end else begin
            hs_s1 <= hs_int;
            if (out_cnt == '0) begin
                vs_s1 <= vs_in;
            end
            rep_s1   <= rep;
            valid_s1 <= valid;
        end
    end

    // Scanline dimming applies to the second replay only.
    always_comb begin
        out_pix = rd_pix;
        if (scanlines && rep_s1) begin
            out_pix = dim_pix(rd_pix);
        end
    end

    // Output registers, blanked until the stream is valid.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            hs_out <= ~SYNC_ACT;
            vs_out <= ~SYNC_ACT;
        end else if (!valid_s1) begin
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            hs_out <= ~SYNC_ACT;
            vs_out <= ~SYNC_ACT;
        end else begin
            r_out  <= out_pix.r;
            g_out  <= out_pix.g;
            b_out  <= out_pix.b;
            hs_out <= hs_s1;
            vs_out <= vs_s1;
        end
    end

    scandoubler_linebuf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_linebuf (
        .clk     (pclk),
        .we      (we),
        .wr_bank (wr_bank),
        .wr_idx  (in_x),
        .wr_data ({r_in, g_in, b_in}),
        .rd_bank (rd_bank),
        .rd_idx  (out_cnt[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_scandoubler.sv
// Directed bench for the scandoubler: line-by-line stimulus with a reference of the previous line.
module tb_scandoubler;

    localparam int HCNT_W    = 12;
    localparam int BUF_DEPTH = 1024;
    localparam int HS_LEN    = 50;

    logic       pclk;
    logic       reset;
    logic       ce_in;
    logic [4:0] r_in, g_in, b_in;
    logic       hs_in, vs_in;
    logic       scanlines;
    logic [4:0] r_out, g_out, b_out;
    logic       hs_out, vs_out;

    int n_vec = 0;
    int n_bad = 0;

    logic [14:0] prev_pix [0:BUF_DEPTH-1];
    logic [14:0] cur_pix  [0:BUF_DEPTH-1];
    int          prev_cnt = 0;
    int          prev_len = 0;

    scandoubler #(
        .HCNT_W    (HCNT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .ce_in     (ce_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .scanlines (scanlines),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // mode 0: i[4:0] on all channels, 1: constant 5'h1E, 2: r/g/b = i[4:0]/i[9:5]/i[10:6]
    function automatic logic [14:0] pix_of(input int mode, input int i);
        logic [10:0] v;
        v = i[10:0];
        case (mode)
            0:       return {v[4:0], v[4:0], v[4:0]};
            1:       return {5'h1E, 5'h1E, 5'h1E};
            default: return {v[4:0], v[9:5], v[10:6]};
        endcase
    endfunction

    function automatic logic [14:0] dim15(input logic [14:0] p);
        return {1'b0, p[14:11], 1'b0, p[9:6], 1'b0, p[4:1]};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rgb"}, {17'd0, r_out, g_out, b_out}, 32'd0);
        check({tag, "_sync"}, {30'd0, hs_out, vs_out}, 32'd3);
    endtask

    // chk 0: no checks, 1: expect blanked outputs, 2: expect replay of previous line.
    // rst_at >= 0 asserts reset asynchronously at that cycle (out_cnt == rst_at - 1).
    task automatic drive_line(input int len, input int mode, input logic vs, input logic scan,
                              input int chk, input int rst_at);
        int   npix;
        int   half;
        int   p;
        int   k;
        int   idx;
        logic rp;
        logic post_rst;
        logic [14:0] ep;
        npix     = 0;
        half     = prev_len / 2;
        post_rst = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge pclk);
            if (reset) reset = 1'b0;
            if (chk == 1 || post_rst) begin
                check_idle("idle");
            end else if (chk == 2 && c >= 3) begin
                p = c - 3;
                if (p < half) begin
                    rp = 1'b0;
                    k  = p;
                end else if (p < 2 * half) begin
                    rp = 1'b1;
                    k  = p - half;
                end else begin
                    rp = 1'b1;
                    k  = half - 1;
                end
                idx = k % BUF_DEPTH;
                if (idx < prev_cnt) begin
                    ep = prev_pix[idx];
                    if (scan && rp) ep = dim15(ep);
                    check("pix", {17'd0, r_out, g_out, b_out}, {17'd0, ep});
                end
                check("sync", {30'd0, hs_out, vs_out},
                      {30'd0, (k < HS_LEN / 2) ? 1'b0 : 1'b1, vs});
            end
            hs_in     = (c < HS_LEN) ? 1'b0 : 1'b1;
            vs_in     = vs;
            scanlines = scan;
            ce_in     = (c % 2 == 1);
            if (c % 2 == 1) begin
                ep = pix_of(mode, npix);
                {r_in, g_in, b_in} = ep;
                if (npix < BUF_DEPTH) cur_pix[npix] = ep;
                npix++;
            end
            if (c == rst_at) begin
                #1 reset = 1'b1;
                #1 check_idle("rst");
                post_rst = 1'b1;
            end
        end
        for (int i = 0; i < BUF_DEPTH; i++) prev_pix[i] = cur_pix[i];
        prev_cnt = (npix > BUF_DEPTH) ? BUF_DEPTH : npix;
        prev_len = len;
    endtask

    initial begin
        reset     = 1'b1;
        ce_in     = 1'b0;
        r_in      = '0;
        g_in      = '0;
        b_in      = '0;
        hs_in     = 1'b1;
        vs_in     = 1'b1;
        scanlines = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) cur_pix[i] = '0;

        // Reset state and startup blanking up to the second line start.
        repeat (4) begin
            @(negedge pclk);
            check_idle("reset");
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge pclk);
            check_idle("pre_e");
        end
        drive_line(682, 0, 1'b1, 1'b0, 1, -1);

        // Steady NES lines; one with vsync active.
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);
        drive_line(682, 0, 1'b0, 1'b0, 2, -1);

        // Short line amid normal lines.
        drive_line(600, 0, 1'b1, 1'b0, 2, -1);
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);

        // Scanlines on a constant 5'h1E field.
        drive_line(682, 1, 1'b1, 1'b0, 2, -1);
        drive_line(682, 1, 1'b1, 1'b1, 2, -1);
        drive_line(682, 1, 1'b1, 1'b1, 2, -1);

        // Overflow: 1100 pixels per line into a 1024-deep bank.
        drive_line(2200, 2, 1'b1, 1'b0, 2, -1);
        drive_line(2200, 2, 1'b1, 1'b0, 2, -1);
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);

        // Asynchronous reset at out_cnt == 100, then requalification.
        drive_line(682, 0, 1'b1, 1'b0, 2, 101);
        drive_line(682, 0, 1'b1, 1'b0, 1, -1);
        drive_line(682, 0, 1'b1, 1'b0, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
